// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
//
// Built-in self-test controller for a single-port memory with a valid/ready
// request handshake. A start pulse writes the pattern P(a) = seed ^ a to every
// address, reads every address back and compares each word against P(a).
// At most one request is outstanding at any time, and every access is bounded
// by a wait-cycle timeout.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          start pulse, accepted only in IDLE or DONE
//   seed_i           pattern seed, captured on an accepted start
//   valid_o          request valid (one-cycle pulse per access)
//   wr_rd_en_o       1 = write, 0 = read
//   addr_o           request address
//   wdata_o          write data (P(addr), also driven during reads)
//   ready_i          memory ready / response strobe
//   rdata_i          memory read data, valid with ready_i during a read wait
//   busy_o           run in progress
//   done_o           run finished; results valid and held
//   pass_o           no miscompare and no timeout
//   timeout_o        run aborted on a handshake timeout
//   err_cnt_o        number of read miscompares
//   first_err_addr_o address of the first miscompare (0 if none)
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  valid_o,
    output logic                  wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_EXPIRE = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Test pattern for address a under seed s (address zero-extended).
    function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0]      s);
        return s ^ WIDTH'(a);
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        seed_q, seed_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     err_q, err_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic                    to_q, to_d;
    logic                    valid_q, valid_d;
    logic                    wr_q, wr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;

    // Next-state, datapath and next-output logic; every output is derived
    // from the next state so the registered outputs line up with the state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        to_d    = to_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    seed_d  = seed_i;
                    err_d   = '0;
                    first_d = '0;
                    to_d    = 1'b0;
                    addr_d  = '0;
                    state_d = ST_WR_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_REQ: begin
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end else if (cnt_q == CNT_EXPIRE) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_REQ: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (ready_i) begin
                    if (rdata_i != pattern(addr_q, seed_q)) begin
                        err_d = err_q + 1'b1;
                        // Only the first miscompare of a run records its address.
                        if (err_q == '0) begin
                            first_d = addr_q;
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end else if (cnt_q == CNT_EXPIRE) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        wr_d    = (state_d == ST_WR_REQ) || (state_d == ST_WR_WAIT);
        wdata_d = pattern(addr_d, seed_d);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        pass_d  = (state_d == ST_DONE) && (err_d == '0) && !to_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            to_q    <= 1'b0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            to_q    <= to_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign valid_o          = valid_q;
    assign wr_rd_en_o       = wr_q;
    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = to_q;
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_ctrl
//
// Bench for mem_bist_ctrl with a one-cycle-latency memory model. Each run
// pushes the expected request stream (64 writes then 64 reads of P(a)) to a
// scoreboard queue; every request seen on valid_o is popped and compared.
// Scenario results come from a table of vectors; reset-mid-run and an
// ignored mid-run start are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

    localparam int W     = 16;
    localparam int D     = 64;
    localparam int AW    = 6;
    localparam int LIMIT = 400;
    localparam int NONE  = 1000000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [W-1:0]  seed_i;
    logic          valid_o;
    logic          wr_rd_en_o;
    logic [AW-1:0] addr_o;
    logic [W-1:0]  wdata_o;
    logic          ready_i;
    logic [W-1:0]  rdata_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] first_err_addr_o;

    mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
        .valid_o(valid_o), .wr_rd_en_o(wr_rd_en_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .ready_i(ready_i), .rdata_i(rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: responds one edge after a request; optional read faults.
    logic [W-1:0] mem [D];
    bit           rdy_en   = 1'b1;
    bit           fault_en = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            ready_i <= 1'b0;
            rdata_i <= '0;
        end else begin
            ready_i <= valid_o && rdy_en;
            if (valid_o) begin
                if (wr_rd_en_o) begin
                    mem[addr_o] <= wdata_o;
                end else begin
                    rdata_i <= mem[addr_o] ^
                               ((fault_en && (addr_o == 6'd5 || addr_o == 6'd40)) ? 16'h0001 : 16'h0000);
                end
            end
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } req_t;
    req_t sb_q[$];

    typedef struct {
        logic [W-1:0] seed;
        bit           fault;
        bit           rdy;
        int           cyc;
        logic         pass;
        logic [AW:0]  err;
        logic [AW-1:0] first;
        logic         to;
        int           remain;
    } vec_t;
    vec_t vecs[4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Runs one BIST pass; cycles = edge index (after start) at which done_o was seen.
    task automatic run(input logic [W-1:0] seed, input bit fault, input bit rdy,
                       input int start_at, input int rst_at, output int cycles);
        bit   prev_valid = 1'b0;
        req_t e;
        fault_en = fault;
        rdy_en   = rdy;
        sb_q.delete();
        for (int a = 0; a < D; a++) sb_q.push_back('{1'b1, AW'(a), seed ^ W'(a)});
        for (int a = 0; a < D; a++) sb_q.push_back('{1'b0, AW'(a), seed ^ W'(a)});
        seed_i  = seed;
        start_i = 1'b1;
        cycles  = -1;
        for (int n = 0; n <= LIMIT; n++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            seed_i  = seed;
            if (n == start_at) begin
                start_i = 1'b1;
                seed_i  = ~seed;
            end
            if (n == rst_at + 1) begin
                chk("rst_valid", valid_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_pass", pass_o, 0);
                chk("rst_to", timeout_o, 0);
                chk("rst_err", err_cnt_o, 0);
                chk("rst_first", first_err_addr_o, 0);
                chk("rst_wr", wr_rd_en_o, 0);
                chk("rst_addr", addr_o, 0);
                chk("rst_wdata", wdata_o, 0);
                rst_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk_i);
                    #1;
                    chk("rst_valid_low", valid_o, 0);
                end
                cycles = n;
                return;
            end
            if (n == rst_at) rst_i = 1'b1;
            if (n == 0) begin
                chk("start_clr_err", err_cnt_o, 0);
                chk("start_clr_first", first_err_addr_o, 0);
                chk("start_clr_to", timeout_o, 0);
                chk("start_clr_done", done_o, 0);
                chk("start_busy", busy_o, 1);
                chk("start_valid", valid_o, 1);
            end
            if (valid_o) begin
                chk("valid_single", prev_valid, 0);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_req", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("req_wr", wr_rd_en_o, e.wr);
                    chk("req_addr", addr_o, e.addr);
                    if (e.wr) chk("req_wdata", wdata_o, e.data);
                end
            end
            prev_valid = valid_o;
            if (done_o) begin
                cycles = n;
                break;
            end
        end
        if (cycles < 0) chk("done_budget", 0, 1);
    endtask

    initial begin
        int cyc;
        rst_i   = 1'b1;
        start_i = 1'b0;
        seed_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid", valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_pass", pass_o, 0);
        chk("reset_err", err_cnt_o, 0);
        chk("reset_wdata", wdata_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        vecs[0] = '{16'hA5A5, 1'b0, 1'b1, 256, 1'b1, 7'd0, 6'd0, 1'b0, 0};
        vecs[1] = '{16'hA5A5, 1'b1, 1'b1, 256, 1'b0, 7'd2, 6'd5, 1'b0, 0};
        vecs[2] = '{16'h1234, 1'b0, 1'b0, 16,  1'b0, 7'd0, 6'd0, 1'b1, 127};
        vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 256, 1'b0, 7'd2, 6'd5, 1'b0, 0};

        for (int i = 0; i < 4; i++) begin
            run(vecs[i].seed, vecs[i].fault, vecs[i].rdy, -1, NONE, cyc);
            chk("vec_cycles", cyc, vecs[i].cyc);
            chk("vec_pass", pass_o, vecs[i].pass);
            chk("vec_err", err_cnt_o, vecs[i].err);
            chk("vec_first", first_err_addr_o, vecs[i].first);
            chk("vec_timeout", timeout_o, vecs[i].to);
            chk("vec_remain", sb_q.size(), vecs[i].remain);
            repeat (2) @(posedge clk_i);
            #1;
            chk("vec_done_hold", done_o, 1);
            chk("vec_busy_low", busy_o, 0);
        end

        // Start pulse mid-run (with a different seed) must be ignored.
        run(16'h5A5A, 1'b1, 1'b1, 50, NONE, cyc);
        chk("ign_cycles", cyc, 256);
        chk("ign_err", err_cnt_o, 2);
        chk("ign_first", first_err_addr_o, 5);
        chk("ign_pass", pass_o, 0);
        chk("ign_remain", sb_q.size(), 0);

        // Reset mid-run, then a clean run with seed 0.
        run(16'h3C3C, 1'b0, 1'b1, -1, 100, cyc);
        run(16'h0000, 1'b0, 1'b1, -1, NONE, cyc);
        chk("post_rst_cycles", cyc, 256);
        chk("post_rst_pass", pass_o, 1);
        chk("post_rst_err", err_cnt_o, 0);
        chk("post_rst_to", timeout_o, 0);
        chk("post_rst_remain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
